// File: rtl/mnist_pkg.sv
// mnist_pkg: shared feature type and helpers for the MNIST pipeline stages.
// No ports; provides feature_type and feature_max (signed max of two features).
package mnist_pkg;

    localparam int FEATURE_WIDTH = 8;

    typedef logic signed [FEATURE_WIDTH-1:0] feature_type;

    function automatic feature_type feature_max(feature_type a, feature_type b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/feature_if.sv
// feature_if: one-feature-per-beat valid/ready stream between pipeline stages.
// Signals: valid, ready, features[0]; producer drives valid/features, consumer drives ready.
interface feature_if;
    import mnist_pkg::*;

    logic        valid;
    logic        ready;
    feature_type features [1];

    modport producer (output valid, output features, input ready);
    modport consumer (input valid, input features, output ready);

endinterface

// File: rtl/pool_row_buffer.sv
// pool_row_buffer: single-port RAM holding one half-width row of partial maxima.
// Ports: clock, i_we, i_addr, i_wdata (write), o_rdata (asynchronous read at i_addr).
module pool_row_buffer
    import mnist_pkg::*;
#(
    parameter int DEPTH = 14,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clock,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  feature_type   i_wdata,
    output feature_type   o_rdata
);

    feature_type r_mem [DEPTH];

    // Contents need no reset: each entry is written on an even row first.
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/maxpool_2x2.sv
// maxpool_2x2: streaming 2x2 stride-2 max pooling of raster-order feature images.
// Ports: clock, reset_n (async, active-low), features_in (consumer), features_out (producer).
module maxpool_2x2
    import mnist_pkg::*;
#(
    parameter int IMAGE_HEIGHT = 28,
    parameter int IMAGE_WIDTH  = 28,
    parameter int NUM_IMAGES   = 20
) (
    input logic         clock,
    input logic         reset_n,
    feature_if.consumer features_in,
    feature_if.producer features_out
);

    localparam int RW = (IMAGE_HEIGHT > 2) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int CW = (IMAGE_WIDTH > 2) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int NW = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1;
    localparam int HW = IMAGE_WIDTH / 2;
    localparam int AW = (HW > 1) ? $clog2(HW) : 1;

    if ((IMAGE_HEIGHT % 2) != 0 || (IMAGE_WIDTH % 2) != 0 ||
        IMAGE_HEIGHT < 2 || IMAGE_WIDTH < 2) begin : g_bad_dims
        $error("maxpool_2x2: IMAGE_HEIGHT and IMAGE_WIDTH must be even and >= 2");
    end

    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic [NW-1:0] r_image_no;
    feature_type   r_hold;
    feature_type   r_out_data;
    logic          r_out_valid;

    logic          w_in_ready;
    logic          w_accept;
    logic          w_row_odd;
    logic          w_col_odd;
    logic          w_last_col;
    logic          w_last_row;
    logic          w_last_img;
    logic          w_complete;
    logic          w_rb_we;
    logic [AW-1:0] w_rb_addr;
    feature_type   w_x;
    feature_type   w_rb_rdata;
    feature_type   w_rb_wdata;

    // Only a full, non-draining output register can stall the input.
    assign w_in_ready = !r_out_valid || features_out.ready;
    assign w_accept   = features_in.valid && w_in_ready;
    assign w_x        = features_in.features[0];

    assign w_row_odd  = r_row[0];
    assign w_col_odd  = r_col[0];
    assign w_last_col = (r_col == CW'(IMAGE_WIDTH - 1));
    assign w_last_row = (r_row == RW'(IMAGE_HEIGHT - 1));
    assign w_last_img = (r_image_no == NW'(NUM_IMAGES - 1));
    assign w_complete = w_accept && w_row_odd && w_col_odd;

    assign w_rb_we    = w_accept && !w_row_odd && w_col_odd;
    assign w_rb_addr  = AW'(r_col >> 1);
    assign w_rb_wdata = feature_max(r_hold, w_x);

    pool_row_buffer #(
        .DEPTH (HW)
    ) u_row_buffer (
        .clock   (clock),
        .i_we    (w_rb_we),
        .i_addr  (w_rb_addr),
        .i_wdata (w_rb_wdata),
        .o_rdata (w_rb_rdata)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_row      <= '0;
            r_col      <= '0;
            r_image_no <= '0;
        end else if (w_accept) begin
            if (w_last_col) begin
                r_col <= '0;
                if (w_last_row) begin
                    r_row      <= '0;
                    r_image_no <= w_last_img ? '0 : r_image_no + NW'(1);
                end else begin
                    r_row <= r_row + RW'(1);
                end
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // Even column: start a window pair (even row) or fold in the buffered
    // upper-row maximum (odd row).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hold <= '0;
        end else if (w_accept && !w_col_odd) begin
            r_hold <= w_row_odd ? feature_max(w_rb_rdata, w_x) : w_x;
        end
    end

    // A new result may load in the same cycle the old one drains.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_complete) begin
            r_out_valid <= 1'b1;
            r_out_data  <= feature_max(r_hold, w_x);
        end else if (features_out.ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign features_in.ready       = w_in_ready;
    assign features_out.valid      = r_out_valid;
    assign features_out.features[0] = r_out_data;

endmodule

// File: doc/maxpool_2x2.md
Name: maxpool_2x2

Overview:
- Streaming 2x2, stride-2 max-pooling stage directly downstream of the convolution layer.
- Consumes one feature per beat in raster order (row-major, image after image) over feature_if.
- Emits one pooled feature per 2x2 window, also in raster order: a 28x28 image becomes 14x14.
- Real hardware: holds only one half-width row of partial maxima, never a full frame.

Parameters:
- IMAGE_HEIGHT, 28, input rows per image; must be even.
- IMAGE_WIDTH, 28, input columns per image; must be even.
- NUM_IMAGES, 20, images per frame; input image counter wraps at this value.

Ports:
- clock  input  1  single clock; all logic on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- features_in  feature_if  n/a  consumer side: drives ready, samples valid and features[0] (feature_type).
- features_out  feature_if  n/a  producer side: drives valid and features[0], samples ready.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low (reset_n).
- Elaboration: $error if IMAGE_HEIGHT or IMAGE_WIDTH is odd, or either is less than 2.
- Reset values: features_out.valid=0, features_out.features[0]=0, in_row/in_col/image_no=0, hold register=0. Row buffer contents are don't-care; every entry is written on an even row before it is read.
- Input accept: a beat is taken when features_in.valid && features_in.ready.
  - features_in.ready = !out_valid || features_out.ready, combinational from registered state.
  - ready never depends on features_in.valid.
- Counters advance on each accepted beat only:
  - in_col wraps at IMAGE_WIDTH-1 and increments in_row.
  - in_row wraps at IMAGE_HEIGHT-1 and increments image_no.
  - image_no wraps at NUM_IMAGES-1 to 0.
- Datapath per accepted pixel x, with k = in_col>>1:
  - Even row, even col: hold <= x.
  - Even row, odd col: rowbuf[k] <= max(hold, x).
  - Odd row, even col: hold <= max(rowbuf[k], x).
  - Odd row, odd col: out_data <= max(hold, x); out_valid <= 1.
- max is a signed compare on feature_type; ties select either value (identical bits). No widening, no saturation.
- Latency: a pooled result is valid on the clock edge after the completing pixel (odd row, odd col) is accepted.
- Output handshake:
  - Data and valid are held stable while valid && !ready.
  - valid drops the cycle after acceptance unless a new result loads in the same cycle.
  - Simultaneous events: output accepted and a completing pixel accepted in the same cycle -> out_data replaced, out_valid stays 1, no bubble.
- Full throughput: 1 input/cycle with downstream ready held high.
- Backpressure: only the output register can stall. When it is full and not draining, input ready is 0 for every pixel, not just completing ones.
- Boundaries:
  - Last pixel of an image: counters return to (0,0) and image_no increments; the next image starts the following beat with no idle gap.
  - No frame-level state machine; streaming is continuous.
- Reset mid-image: all counters clear and out_valid drops immediately (asynchronous). The partial image is discarded; the next accepted pixel is treated as (row 0, col 0) of image 0.
- Ordering: output count per image = (IMAGE_HEIGHT/2)*(IMAGE_WIDTH/2), emitted in pooled raster order.

Decomposition:
- feature_type and the feature_if interface stay in mnist_pkg as-is.
- Add to mnist_pkg: function automatic feature_type feature_max(feature_type a, b), signed compare, shared with later pooling/ReLU stages.
- One natural sub-module: pool_row_buffer (IMAGE_WIDTH/2-entry single-port RAM, feature_type wide).
  - Write on even-row odd-col beats; read on odd-row even-col beats.
  - Same-address read/write never occurs in the same cycle.
- Row/column counters and output register stay in the top module.

Test Plan:
- IMAGE 4x4, NUM_IMAGES=1, pixels 0..15 raster, out.ready=1 -> outputs 5,7,13,15 in order, each one cycle after pixels 5,7,13,15 are accepted; in.ready constantly 1.
- Signed values: window {-5,-2,-7,-1} -> -1; window {-8,-8,-8,-8} -> -8; window {-3,4,0,-9} -> 4.
- Backpressure: out.ready=0 for 10 cycles while the first result is valid -> out.features[0] stable at 5, valid stays 1, in.ready=0. Release -> no result lost or duplicated.
- Default 28x28, NUM_IMAGES=2, random data, continuous valid -> exactly 392 outputs matching a reference model; image 2 starts with no gap; image_no returns to 0.
- Simultaneous drain and load: out.ready=1 while the next completing pixel arrives -> valid stays high across both results, no bubble cycle.
- Assert reset_n=0 after 37 pixels of a 28x28 image -> valid=0 immediately. After release, a fresh 28x28 image yields 196 correct outputs with no stale data.
